// File: rtl/config_frame_loader.sv
// config_frame_loader: receives framed configuration writes over a valid/ready
// byte stream and turns each good frame into a one-cycle register bank write.
// A frame is a header (bit7 set, bits[6:0] address), dataBytes data bytes
// (LSB first) and a checksum byte that makes the whole frame sum to 0 mod 256.
module config_frame_loader #(
  parameter int dataBytes = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [7:0]             IN_BYTE,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   ABORT,
  output logic                   WR_EN,
  output logic [6:0]             WR_ADDR,
  output logic [8*dataBytes-1:0] WR_DATA,
  output logic                   BUSY,
  output logic [7:0]             ERR_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CSUM,
    WRITE
  } state_t;

  state_t state;
  state_t next_state;

  logic [6:0]             pend_addr;
  logic [8*dataBytes-1:0] pend_data;
  logic [7:0]             sum;
  logic [2:0]             cnt;

  logic       take;
  logic       accept;
  logic       last_byte;
  logic [7:0] csum_sum;
  logic       csum_ok;
  logic       err_inc;

  // A byte moves when both sides agree; ABORT throws that byte away.
  assign take      = IN_VALID && IN_READY;
  assign accept    = take && !ABORT;
  assign last_byte = (cnt == 3'(dataBytes - 1));
  assign csum_sum  = sum + IN_BYTE;
  assign csum_ok   = (csum_sum == 8'd0);

  // Handshake and status outputs depend on the state alone.
  assign IN_READY = (state != WRITE);
  assign BUSY     = (state != IDLE);
  assign WR_EN    = (state == WRITE);

  // Stray non-header bytes in IDLE and failed checksums are both counted.
  assign err_inc = accept && (((state == IDLE) && !IN_BYTE[7]) ||
                              ((state == CSUM) && !csum_ok));

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; ABORT only matters while a frame is being collected.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && IN_BYTE[7]) next_state = DATA;
      end
      DATA: begin
        if (ABORT)                  next_state = IDLE;
        else if (take && last_byte) next_state = CSUM;
      end
      CSUM: begin
        if (ABORT)     next_state = IDLE;
        else if (take) next_state = csum_ok ? WRITE : IDLE;
      end
      WRITE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame assembly: latch the address, fill data lanes, keep a running sum.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_addr <= '0;
      pend_data <= '0;
      sum       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      if ((state == IDLE) && IN_BYTE[7]) begin
        pend_addr <= IN_BYTE[6:0];
        sum       <= IN_BYTE;
        cnt       <= '0;
      end else if (state == DATA) begin
        for (int i = 0; i < dataBytes; i++) begin
          if (cnt == 3'(i)) pend_data[i*8 +: 8] <= IN_BYTE;
        end
        sum <= csum_sum;
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Visible write address/data only change on the edge that enters WRITE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WR_ADDR <= '0;
      WR_DATA <= '0;
    end else if (accept && (state == CSUM) && csum_ok) begin
      WR_ADDR <= pend_addr;
      WR_DATA <= pend_data;
    end
  end

  // Saturating error counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                          ERR_CNT <= '0;
    else if (err_inc && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// tb_config_frame_loader: scenario tasks drive byte streams into
// config_frame_loader and compare against a frame-level reference model.
module tb_config_frame_loader;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  IN_BYTE;
  logic        IN_VALID;
  logic        IN_READY;
  logic        ABORT;
  logic        WR_EN;
  logic [6:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        BUSY;
  logic [7:0]  ERR_CNT;

  int n_compared   = 0;
  int n_mismatched = 0;
  int wr_pulses    = 0;
  int cyc          = 0;

  // Reference model state: last written address/data, error count, writes.
  logic [6:0]  exp_addr;
  logic [31:0] exp_data;
  logic [7:0]  exp_err;
  int          exp_pulses;

  config_frame_loader #(.dataBytes(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_BYTE(IN_BYTE), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .ABORT(ABORT), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  always @(negedge CLK) if (WR_EN === 1'b1) wr_pulses++;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Present a byte from a negedge and hold it until it is transferred;
  // returns at the negedge after the transferring posedge.
  task automatic push_byte(input logic [7:0] b, input logic abort, output int waited);
    IN_BYTE  = b;
    IN_VALID = 1'b1;
    ABORT    = abort;
    waited   = 0;
    while (IN_READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 20) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL push_timeout: IN_READY=%b never became 1", IN_READY);
    end
    @(negedge CLK);
    ABORT = 1'b0;
  endtask

  task automatic go_idle(input int n);
    IN_VALID = 1'b0;
    ABORT    = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  // Send one complete frame and check the outcome in the cycle after the checksum.
  task automatic send_frame(input logic [6:0] addr, input logic [31:0] data,
                            input logic corrupt, input logic gaps, output int hdr_wait);
    logic [7:0] s;
    logic [7:0] csum;
    int w;
    s = {1'b1, addr};
    push_byte(s, 1'b0, hdr_wait);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        IN_VALID = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      push_byte(data[i*8 +: 8], 1'b0, w);
      s = s + data[i*8 +: 8];
    end
    csum = 8'd0 - s;
    if (corrupt) csum = csum + 8'($urandom_range(1, 255));
    if (gaps) begin
      IN_VALID = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    push_byte(csum, 1'b0, w);
    n_compared++;
    if (!corrupt) begin
      exp_addr = addr;
      exp_data = data;
      exp_pulses++;
      if (WR_EN !== 1'b1 || WR_ADDR !== exp_addr || WR_DATA !== exp_data ||
          IN_READY !== 1'b0 || ERR_CNT !== exp_err) begin
        n_mismatched++;
        $display("[TB] FAIL frame_write: got en=%b addr=%h data=%h rdy=%b err=%0d expected en=1 addr=%h data=%h rdy=0 err=%0d",
                 WR_EN, WR_ADDR, WR_DATA, IN_READY, ERR_CNT, exp_addr, exp_data, exp_err);
      end
    end else begin
      exp_err = sat_inc(exp_err);
      if (WR_EN !== 1'b0 || WR_ADDR !== exp_addr || WR_DATA !== exp_data ||
          ERR_CNT !== exp_err || BUSY !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL frame_drop: got en=%b addr=%h data=%h err=%0d busy=%b expected en=0 addr=%h data=%h err=%0d busy=0",
                 WR_EN, WR_ADDR, WR_DATA, ERR_CNT, BUSY, exp_addr, exp_data, exp_err);
      end
    end
  endtask

  task automatic test_reset();
    RST_N    = 1'b0;
    IN_BYTE  = 8'h00;
    IN_VALID = 1'b0;
    ABORT    = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_err  = '0;
    exp_pulses = 0;
    repeat (2) @(negedge CLK);
    n_compared++;
    if (WR_EN !== 1'b0 || WR_ADDR !== 7'h00 || WR_DATA !== 32'h0 ||
        ERR_CNT !== 8'h00 || BUSY !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_values: got en=%b addr=%h data=%h err=%0d busy=%b expected all 0",
               WR_EN, WR_ADDR, WR_DATA, ERR_CNT, BUSY);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    n_compared++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release: got rdy=%b busy=%b expected rdy=1 busy=0", IN_READY, BUSY);
    end
  endtask

  task automatic test_good_frame();
    int w;
    logic [7:0] bytes [6];
    bytes = '{8'h85, 8'h11, 8'h22, 8'h33, 8'h44, 8'hD1};
    for (int i = 0; i < 6; i++) push_byte(bytes[i], 1'b0, w);
    exp_addr = 7'h05;
    exp_data = 32'h44332211;
    exp_pulses++;
    n_compared++;
    if (WR_EN !== 1'b1 || WR_ADDR !== 7'h05 || WR_DATA !== 32'h44332211 ||
        IN_READY !== 1'b0 || ERR_CNT !== 8'h00 || BUSY !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL good_frame: got en=%b addr=%h data=%h rdy=%b err=%0d busy=%b expected en=1 addr=05 data=44332211 rdy=0 err=0 busy=1",
               WR_EN, WR_ADDR, WR_DATA, IN_READY, ERR_CNT, BUSY);
    end
    go_idle(1);
    n_compared++;
    if (WR_EN !== 1'b0 || IN_READY !== 1'b1 || WR_DATA !== 32'h44332211 || WR_ADDR !== 7'h05) begin
      n_mismatched++;
      $display("[TB] FAIL good_frame_after: got en=%b rdy=%b addr=%h data=%h expected en=0 rdy=1 addr=05 data=44332211",
               WR_EN, IN_READY, WR_ADDR, WR_DATA);
    end
  endtask

  task automatic test_bad_checksum();
    int w;
    int p0;
    logic [7:0] bytes [6];
    bytes = '{8'h85, 8'h11, 8'h22, 8'h33, 8'h44, 8'hD0};
    p0 = wr_pulses;
    for (int i = 0; i < 6; i++) push_byte(bytes[i], 1'b0, w);
    go_idle(2);
    exp_err = sat_inc(exp_err);
    n_compared++;
    if (ERR_CNT !== 8'd1 || WR_DATA !== 32'h44332211 || wr_pulses !== p0) begin
      n_mismatched++;
      $display("[TB] FAIL bad_checksum: got err=%0d data=%h pulses=%0d expected err=1 data=44332211 pulses=%0d",
               ERR_CNT, WR_DATA, wr_pulses, p0);
    end
    send_frame(7'($urandom), $urandom, 1'b0, 1'b0, w);
    go_idle(1);
  endtask

  task automatic test_stray();
    int w;
    push_byte(8'h05, 1'b0, w);
    push_byte(8'h7F, 1'b0, w);
    exp_err = sat_inc(sat_inc(exp_err));
    n_compared++;
    if (ERR_CNT !== exp_err || BUSY !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL stray_bytes: got err=%0d busy=%b expected err=%0d busy=0", ERR_CNT, BUSY, exp_err);
    end
    send_frame(7'h01, $urandom, 1'b0, 1'b0, w);
    go_idle(1);
  endtask

  task automatic test_abort();
    int w;
    int p0;
    p0 = wr_pulses;
    push_byte(8'h83, 1'b0, w);
    push_byte(8'hA5, 1'b0, w);
    push_byte(8'h5A, 1'b0, w);
    push_byte(8'h3C, 1'b1, w);
    n_compared++;
    if (BUSY !== 1'b0 || ERR_CNT !== exp_err) begin
      n_mismatched++;
      $display("[TB] FAIL abort_data: got busy=%b err=%0d expected busy=0 err=%0d", BUSY, ERR_CNT, exp_err);
    end
    go_idle(8);
    n_compared++;
    if (wr_pulses !== p0 || WR_ADDR !== exp_addr || WR_DATA !== exp_data) begin
      n_mismatched++;
      $display("[TB] FAIL abort_nowrite: got pulses=%0d addr=%h data=%h expected pulses=%0d addr=%h data=%h",
               wr_pulses, WR_ADDR, WR_DATA, p0, exp_addr, exp_data);
    end
    push_byte(8'h12, 1'b1, w);
    n_compared++;
    if (ERR_CNT !== exp_err || BUSY !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_idle: got err=%0d busy=%b expected err=%0d busy=0", ERR_CNT, BUSY, exp_err);
    end
    send_frame(7'($urandom), $urandom, 1'b0, 1'b0, w);
    go_idle(1);
  endtask

  task automatic test_reset_mid_frame();
    int w;
    push_byte(8'hB3, 1'b0, w);
    push_byte(8'h01, 1'b0, w);
    push_byte(8'h02, 1'b0, w);
    #2 RST_N = 1'b0;
    #1;
    n_compared++;
    if (WR_EN !== 1'b0 || WR_ADDR !== 7'h00 || WR_DATA !== 32'h0 ||
        ERR_CNT !== 8'h00 || BUSY !== 1'b0 || IN_READY !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid: got en=%b addr=%h data=%h err=%0d busy=%b rdy=%b expected 0/0/0/0/0 rdy=1",
               WR_EN, WR_ADDR, WR_DATA, ERR_CNT, BUSY, IN_READY);
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST_N    = 1'b1;
    exp_addr = '0;
    exp_data = '0;
    exp_err  = '0;
    @(negedge CLK);
    send_frame(7'($urandom), $urandom, 1'b0, 1'b1, w);
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    int w1;
    int w2;
    int c0;
    send_frame(7'($urandom), $urandom, 1'b0, 1'b0, w1);
    c0 = cyc;
    send_frame(7'($urandom), $urandom, 1'b0, 1'b0, w2);
    n_compared++;
    if (w2 !== 1 || (cyc - c0) !== 7) begin
      n_mismatched++;
      $display("[TB] FAIL back_to_back: got hdr_wait=%0d period=%0d expected hdr_wait=1 period=7", w2, cyc - c0);
    end
    go_idle(1);
  endtask

  task automatic test_random();
    int w;
    int kind;
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 7);
      if (kind == 7) begin
        push_byte(8'($urandom_range(0, 127)), 1'b0, w);
        exp_err = sat_inc(exp_err);
        n_compared++;
        if (ERR_CNT !== exp_err || BUSY !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL random_stray: got err=%0d busy=%b expected err=%0d busy=0", ERR_CNT, BUSY, exp_err);
        end
      end else begin
        send_frame(7'($urandom), $urandom, kind == 6, 1'($urandom), w);
      end
      if ($urandom_range(0, 1) == 1) go_idle($urandom_range(1, 3));
    end
    go_idle(2);
    n_compared++;
    if (wr_pulses !== exp_pulses) begin
      n_mismatched++;
      $display("[TB] FAIL write_count: got %0d expected %0d", wr_pulses, exp_pulses);
    end
  endtask

  task automatic test_saturation();
    int w;
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      push_byte(8'($urandom_range(0, 127)), 1'b0, w);
      exp_err = sat_inc(exp_err);
      if (ERR_CNT !== exp_err) bad++;
    end
    n_compared++;
    if (bad != 0 || ERR_CNT !== 8'd255) begin
      n_mismatched++;
      $display("[TB] FAIL saturation: got err=%0d (%0d step errors) expected err=255", ERR_CNT, bad);
    end
    send_frame(7'($urandom), $urandom, 1'b1, 1'b0, w);
    go_idle(1);
    n_compared++;
    if (ERR_CNT !== 8'd255) begin
      n_mismatched++;
      $display("[TB] FAIL saturation_hold: got err=%0d expected err=255", ERR_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_stray();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/config_frame_loader.md
# config_frame_loader

Byte-stream front end for the configuration register bank. It accepts framed configuration writes over a valid/ready byte interface, assembles each frame's address and data, and checks a modulo-256 checksum. For each valid frame it issues a single-cycle write strobe that drives the EN/D_IN inputs of the selected asynchronously-reset config register. Malformed frames are dropped and counted.

## Interface
- dataBytes, default 4: data bytes per frame; data word width is 8*dataBytes; legal range 1..8.
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  reset; one clock, asynchronous, active-low.
- IN_BYTE  input  8  stream byte.
- IN_VALID  input  1  IN_BYTE is valid this cycle.
- IN_READY  output  1  block accepts a byte this cycle; transfer occurs when IN_VALID && IN_READY.
- ABORT  input  1  synchronous frame abort.
- WR_EN  output  1  one-cycle write strobe to the config register bank.
- WR_ADDR  output  7  target register address, held between writes.
- WR_DATA  output  8*dataBytes  write data, held between writes.
- BUSY  output  1  high whenever the state is not IDLE.
- ERR_CNT  output  8  count of dropped frames and stray bytes; saturates at 255.

## Operation
- Frame format:
  - Header byte: bit7 = 1 marks start of frame; bits[6:0] are the address.
  - Then dataBytes data bytes, least-significant byte first.
  - Then one checksum byte.
  - The frame is valid when (header + all data bytes + checksum) mod 256 = 0.
- States: IDLE, DATA, CSUM, WRITE.
- IDLE:
  - On accepting a byte with bit7 = 1: latch bits[6:0] as the pending address, set the running sum to the byte, clear the byte counter, go to DATA.
  - On accepting a byte with bit7 = 0: discard it, increment ERR_CNT, stay in IDLE.
- DATA:
  - Each accepted byte goes into pending-data lane [counter] and is added to the sum.
  - After byte dataBytes-1, go to CSUM.
- CSUM:
  - On accepting a byte, compute (sum + byte) mod 256.
  - If the result is 0: copy the pending address and data to WR_ADDR/WR_DATA and go to WRITE.
  - Otherwise: increment ERR_CNT and go to IDLE; WR_ADDR/WR_DATA are unchanged.
- WRITE: WR_EN = 1 for exactly this cycle, then go to IDLE.
- IN_READY = 1 in IDLE, DATA and CSUM; 0 in WRITE. IN_READY is derived from state only, never from IN_VALID.
- Bytes presented while IN_READY = 0 are not consumed; the producer holds them.
- ABORT in DATA or CSUM:
  - Return to IDLE next cycle; any byte transferred in the same cycle is discarded.
  - No write occurs; ERR_CNT is unchanged.
  - The pending address/data may remain stale; they are not visible on outputs.
- ABORT in IDLE: no effect, but a byte transferred that cycle is discarded and not counted.
- ABORT in WRITE: ignored; the write completes.
- A header byte arriving in DATA or CSUM is treated as data or checksum; there is no resynchronisation except via checksum failure or ABORT.
- ERR_CNT holds at 255 once it reaches 255.

## Timing
- Reset values: state IDLE, WR_EN 0, WR_ADDR 0, WR_DATA 0, ERR_CNT 0, BUSY 0.
- IN_READY is 1 as soon as RST_N deasserts.
- Reset asserted mid-frame: outputs return to reset values immediately and the partial frame is lost.
- With continuous IN_VALID, header accepted at cycle 0:
  - Data bytes are accepted at cycles 1..dataBytes.
  - The checksum is accepted at cycle dataBytes+1.
  - WR_EN and the new WR_ADDR/WR_DATA appear at cycle dataBytes+2.
  - IN_READY = 1 again at cycle dataBytes+3.
- Throughput: dataBytes+3 cycles per frame at best.
- WR_ADDR/WR_DATA change only at the clock edge that enters WRITE. They are stable for the whole WR_EN cycle and afterward.
- ERR_CNT updates one cycle after the offending byte transfer.
- Gaps in IN_VALID stall the FSM without timeout.

## Test plan
- Good frame (dataBytes=4): 0x85, 0x11, 0x22, 0x33, 0x44, 0xD1 back-to-back from cycle 0 -> at cycle 6, WR_EN=1, WR_ADDR=0x05, WR_DATA=0x44332211; IN_READY=0 at cycle 6; ERR_CNT=0.
- Bad checksum: same frame with checksum 0xD0 -> WR_EN never asserts; ERR_CNT=1; WR_DATA keeps its previous value; the next good frame writes normally.
- Stray bytes: 0x05 then 0x7F in IDLE -> ERR_CNT=2, BUSY stays 0; a following good frame to address 0x01 writes correctly.
- Abort: header 0x83 and two data bytes, then ABORT=1 with IN_VALID=1 -> IDLE, no WR_EN, ERR_CNT unchanged; the next good frame writes correctly.
- Reset mid-frame and back-pressure:
  - Drop RST_N asynchronously after 3 bytes -> all outputs go to reset values at once; after release, a full frame with random IN_VALID gaps writes the correct value.
  - Hold IN_VALID high through WRITE -> the held byte is accepted only in the following cycle.
- Saturation: 300 stray bytes -> ERR_CNT=255 and holding.
